// File: rtl/rgb565_gray_pack_ci_pkg.sv
// Shared constants and helpers for the RGB565 -> gray8 custom instruction.
// Holds default luma weights, RGB565 field positions, pipeline depth bounds
// and the 5/6-bit to 8-bit channel expansion used by every pixel lane.
package rgb565_gray_pack_ci_pkg;

    // Default luma weights (sum to 256 so the weighted sum never overflows 16 bits)
    localparam int DEF_R_WEIGHT = 54;
    localparam int DEF_G_WEIGHT = 183;
    localparam int DEF_B_WEIGHT = 19;
    localparam int WEIGHT_TOTAL = 256;

    // RGB565 field positions
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Legal pipeline depths
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // MSB replication fills the low bits so full-scale 5/6-bit maps to 8'hFF
    function automatic rgb888_t expand565(input logic [15:0] px);
        rgb888_t c;
        c.r = {px[R_MSB:R_LSB], px[R_MSB -: 3]};
        c.g = {px[G_MSB:G_LSB], px[G_MSB -: 2]};
        c.b = {px[B_MSB:B_LSB], px[B_MSB -: 3]};
        return c;
    endfunction

endpackage

// File: rtl/rgb565_gray_pack_ci_to_gray8.sv
// One-pixel RGB565 -> 8-bit gray lane (module rgb565_to_gray8).
// Latency: LATENCY cycles of cke=1 (stage registers chosen by LATENCY).
// Backpressure: all stage registers hold while cke=0.
// Ports: clock/reset (async active-high), cke stage enable, pixel RGB565 in,
// gray registered 8-bit luma out.
// Build option GRAY_ROUND_EN: round half-up (+128) with saturation to 8'hFF
// instead of truncating the weighted sum.
module rgb565_to_gray8
    import rgb565_gray_pack_ci_pkg::*;
#(
    parameter int R_WEIGHT = DEF_R_WEIGHT,
    parameter int G_WEIGHT = DEF_G_WEIGHT,
    parameter int B_WEIGHT = DEF_B_WEIGHT,
    parameter int LATENCY  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cke,
    input  logic [15:0] pixel,
    output logic [7:0]  gray
);

    localparam logic [15:0] WR = 16'(R_WEIGHT);
    localparam logic [15:0] WG = 16'(G_WEIGHT);
    localparam logic [15:0] WB = 16'(B_WEIGHT);

    rgb888_t     exp_c;
    rgb888_t     exp_s;
    logic [15:0] pr_c, pg_c, pb_c;
    logic [15:0] pr_s, pg_s, pb_s;
    logic [15:0] sum_c;
    logic [7:0]  gray_c;

    assign exp_c = expand565(pixel);

    // Stage 1: expanded channels, only registered in the 3-deep pipeline
    generate
        if (LATENCY == 3) begin : g_s1_reg
            rgb888_t exp_q;
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    exp_q <= '0;
                else if (cke)
                    exp_q <= exp_c;
            end
            assign exp_s = exp_q;
        end else begin : g_s1_bypass
            assign exp_s = exp_c;
        end
    endgenerate

    assign pr_c = WR * {8'h00, exp_s.r};
    assign pg_c = WG * {8'h00, exp_s.g};
    assign pb_c = WB * {8'h00, exp_s.b};

    // Stage 2: products, registered for depths 2 and 3
    generate
        if (LATENCY >= 2) begin : g_s2_reg
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pr_s <= '0;
                    pg_s <= '0;
                    pb_s <= '0;
                end else if (cke) begin
                    pr_s <= pr_c;
                    pg_s <= pg_c;
                    pb_s <= pb_c;
                end
            end
        end else begin : g_s2_bypass
            assign pr_s = pr_c;
            assign pg_s = pg_c;
            assign pb_s = pb_c;
        end
    endgenerate

    assign sum_c = pr_s + pg_s + pb_s;

`ifdef GRAY_ROUND_EN
    logic [16:0] sum_rnd;
    assign sum_rnd = {1'b0, sum_c} + 17'd128;
    assign gray_c  = sum_rnd[16] ? 8'hFF : 8'(sum_rnd >> 8);
`else
    assign gray_c = 8'(sum_c >> 8);
`endif

    // Stage 3: final gray byte, always registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            gray <= '0;
        else if (cke)
            gray <= gray_c;
    end

endmodule

// File: rtl/rgb565_gray_pack_ci.sv
// Custom-instruction unit: four RGB565 pixels -> four packed gray bytes.
// Latency: LATENCY (1..3) ciCke=1 cycles from accepted ciStart to ciDone pulse.
// Backpressure: ciCke=0 freezes data and valid pipes and holds ciDone low.
// Ports: clock/reset (async active-high); ciStart/ciCke/ciN issue controls;
// ciDataA pixels -> bytes 0/1, ciDataB pixels -> bytes 2/3; ciDone pulse and
// ciResult (zero whenever ciDone=0). Build option GRAY_ROUND_EN selects
// rounded/saturated gray in every lane without changing latency.
module rgb565_gray_pack_ci
    import rgb565_gray_pack_ci_pkg::*;
#(
    parameter logic [7:0] CUSTOM_ID = 8'd0,
    parameter int         R_WEIGHT  = DEF_R_WEIGHT,
    parameter int         G_WEIGHT  = DEF_G_WEIGHT,
    parameter int         B_WEIGHT  = DEF_B_WEIGHT,
    parameter int         LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciDataA,
    input  logic [31:0] ciDataB,
    output logic        ciDone,
    output logic [31:0] ciResult
);

    generate
        if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
            $error("rgb565_gray_pack_ci: LATENCY must be 1..3");
        end
        if (R_WEIGHT + G_WEIGHT + B_WEIGHT != WEIGHT_TOTAL) begin : g_bad_weights
            $error("rgb565_gray_pack_ci: R_WEIGHT+G_WEIGHT+B_WEIGHT must equal 256");
        end
    endgenerate

    logic [63:0]        pixels;
    logic [31:0]        gray_all;
    logic               accept;
    logic [LATENCY-1:0] vld_q;

    assign pixels = {ciDataB, ciDataA};
    assign accept = ciStart & ciCke & (ciN == CUSTOM_ID);

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            rgb565_to_gray8 #(
                .R_WEIGHT (R_WEIGHT),
                .G_WEIGHT (G_WEIGHT),
                .B_WEIGHT (B_WEIGHT),
                .LATENCY  (LATENCY)
            ) u_gray (
                .clock (clock),
                .reset (reset),
                .cke   (ciCke),
                .pixel (pixels[16*i +: 16]),
                .gray  (gray_all[8*i +: 8])
            );
        end
    endgenerate

    // Valid shifts alongside the data; the cast drops the bit leaving the top
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            vld_q <= '0;
        else if (ciCke)
            vld_q <= LATENCY'({vld_q, accept});
    end

    assign ciDone   = vld_q[LATENCY-1] & ciCke;
    assign ciResult = ciDone ? gray_all : 32'd0;

endmodule

// File: tb/tb_rgb565_gray_pack_ci.sv
module tb_rgb565_gray_pack_ci;

    localparam logic [7:0] CID = 8'd0;
    localparam int NC = 12;

    logic        clock = 1'b0;
    logic        reset;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciDataA;
    logic [31:0] ciDataB;

    wire         dn1, dn2, dn3;
    wire  [31:0] rs1, rs2, rs3;
    wire  [2:0]  dn_all = {dn3, dn2, dn1};
    wire  [95:0] rs_all = {rs3, rs2, rs1};

    always #5 clock = ~clock;

    rgb565_gray_pack_ci #(.CUSTOM_ID(CID), .R_WEIGHT(54), .G_WEIGHT(183), .B_WEIGHT(19), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciDataA(ciDataA), .ciDataB(ciDataB), .ciDone(dn1), .ciResult(rs1));
    rgb565_gray_pack_ci dut2 (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciDataA(ciDataA), .ciDataB(ciDataB), .ciDone(dn2), .ciResult(rs2));
    rgb565_gray_pack_ci #(.CUSTOM_ID(CID), .LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciDataA(ciDataA), .ciDataB(ciDataB), .ciDone(dn3), .ciResult(rs3));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_trunc;
        logic [31:0] exp_round;
    } vec_t;

    vec_t vt[6];

    int n_vec = 0;
    int n_err = 0;

    // per-cycle stimulus script
    logic [31:0] st_a[NC];
    logic [31:0] st_b[NC];
    logic        st_start[NC];
    logic        st_cke[NC];
    logic        st_rst[NC];
    logic [7:0]  st_n[NC];

    // captured done pulses per instance (index 0..2 -> LATENCY 1..3)
    int          got_n[3];
    int          bad_res[3];
    int          got_c[3][4];
    logic [31:0] got_r[3][4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input vec_t v);
`ifdef GRAY_ROUND_EN
        return v.exp_round;
`else
        return v.exp_trunc;
`endif
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < NC; i++) begin
            st_a[i] = 32'd0; st_b[i] = 32'd0; st_start[i] = 1'b0;
            st_cke[i] = 1'b1; st_rst[i] = 1'b0; st_n[i] = CID;
        end
    endtask

    // Entered and left #1 after a rising edge; cycle 0 is the issue cycle.
    task automatic run_seq();
        for (int d = 0; d < 3; d++) begin
            got_n[d] = 0;
            bad_res[d] = 0;
        end
        for (int i = 0; i < NC; i++) begin
            reset = st_rst[i]; ciStart = st_start[i]; ciCke = st_cke[i];
            ciN = st_n[i]; ciDataA = st_a[i]; ciDataB = st_b[i];
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                if (dn_all[d]) begin
                    if (got_n[d] < 4) begin
                        got_c[d][got_n[d]] = i;
                        got_r[d][got_n[d]] = rs_all[32*d +: 32];
                    end
                    got_n[d]++;
                end else if (rs_all[32*d +: 32] != 32'd0) begin
                    bad_res[d]++;
                end
            end
            @(posedge clock);
            #1;
        end
        reset = 1'b0; ciStart = 1'b0; ciCke = 1'b1;
    endtask

    // Expect n pulses per instance at cycle LATENCY+offset, with given results.
    task automatic check_seq(input string nm, input int n,
                             input int o0, input int o1, input int o2,
                             input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        int offs[3];
        logic [31:0] rr[3];
        offs[0] = o0; offs[1] = o1; offs[2] = o2;
        rr[0] = r0; rr[1] = r1; rr[2] = r2;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s lat%0d done_count", nm, d + 1), 32'(got_n[d]), 32'(n));
            check($sformatf("%s lat%0d result_gate", nm, d + 1), 32'(bad_res[d]), 32'd0);
            for (int k = 0; k < n && k < got_n[d] && k < 3; k++) begin
                check($sformatf("%s lat%0d done_cycle%0d", nm, d + 1, k), 32'(got_c[d][k]), 32'(d + 1 + offs[k]));
                check($sformatf("%s lat%0d result%0d", nm, d + 1, k), got_r[d][k], rr[k]);
            end
        end
    endtask

    initial begin
        // a, b, truncated result, rounded result (hand-computed, weights 54/183/19)
        vt[0] = '{32'hFFFF_0000, 32'hF800_07E0, 32'h35B6_FF00, 32'h36B6_FF00};
        vt[1] = '{32'h001F_001F, 32'h0000_0000, 32'h0000_1212, 32'h0000_1313};
        vt[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vt[4] = '{32'h8410_8410, 32'h0000_8410, 32'h0082_8282, 32'h0083_8383};
        vt[5] = '{32'h0000_0000, 32'h1234_0000, 32'h4000_0000, 32'h4100_0000};

        reset = 1'b1; ciStart = 1'b0; ciCke = 1'b1; ciN = CID;
        ciDataA = 32'd0; ciDataB = 32'd0;

        // reset state
        @(negedge clock);
        @(negedge clock);
        check("reset done1", {31'd0, dn1}, 32'd0);
        check("reset done2", {31'd0, dn2}, 32'd0);
        check("reset done3", {31'd0, dn3}, 32'd0);
        check("reset result1", rs1, 32'd0);
        check("reset result2", rs2, 32'd0);
        check("reset result3", rs3, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // single issues from the table
        for (int v = 0; v < 6; v++) begin
            clear_stim();
            st_start[0] = 1'b1; st_a[0] = vt[v].a; st_b[0] = vt[v].b;
            run_seq();
            check_seq($sformatf("vec%0d", v), 1, 0, 0, 0, pick(vt[v]), 32'd0, 32'd0);
        end

        // foreign id is ignored
        clear_stim();
        st_start[0] = 1'b1; st_n[0] = 8'(CID + 8'd1);
        st_a[0] = vt[0].a; st_b[0] = vt[0].b;
        run_seq();
        check_seq("wrong_id", 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

        // start while ciCke=0 is not an accept
        clear_stim();
        st_start[0] = 1'b1; st_cke[0] = 1'b0;
        st_a[0] = vt[0].a; st_b[0] = vt[0].b;
        run_seq();
        check_seq("start_no_cke", 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

        // two-cycle stall right after the accept delays every depth by two
        clear_stim();
        st_start[0] = 1'b1; st_a[0] = vt[0].a; st_b[0] = vt[0].b;
        st_cke[1] = 1'b0; st_cke[2] = 1'b0;
        run_seq();
        check_seq("stall", 1, 2, 0, 0, pick(vt[0]), 32'd0, 32'd0);

        // back-to-back issues come out in order on consecutive cycles
        clear_stim();
        st_start[0] = 1'b1; st_a[0] = vt[0].a; st_b[0] = vt[0].b;
        st_start[1] = 1'b1; st_a[1] = vt[1].a; st_b[1] = vt[1].b;
        st_start[2] = 1'b1; st_a[2] = vt[4].a; st_b[2] = vt[4].b;
        run_seq();
        check_seq("b2b", 3, 0, 1, 2, pick(vt[0]), pick(vt[1]), pick(vt[4]));

        // reset one cycle after the accept drops the instruction
        clear_stim();
        st_start[0] = 1'b1; st_a[0] = vt[0].a; st_b[0] = vt[0].b;
        st_rst[1] = 1'b1;
        run_seq();
        check_seq("mid_reset", 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);

        // next accept after that reset completes normally
        clear_stim();
        st_start[0] = 1'b1; st_a[0] = vt[5].a; st_b[0] = vt[5].b;
        run_seq();
        check_seq("after_reset", 1, 0, 0, 0, pick(vt[5]), 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
